// File: rtl/reg_file_mp_if.sv
// Bundle of decode-side read/issue signals and writeback signals for reg_file_mp.
// The master drives addresses, strobes and write data. The slave (the register
// file) returns read data, busy flags and ready.
interface reg_file_mp_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, ready
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with write-to-read forwarding and a
// per-register busy scoreboard. Storage has no reset. After reset, a sweep
// writes zero into one register per cycle. The block reports ready once every
// register has been cleared.
module reg_file_mp #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     cnt_reg, cnt_next;
    logic              run;

    logic [XLEN-1:0]   mem [NREGS];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;

    logic [NREGS-1:0]  busy_reg;
    logic [NREGS-1:0]  busy_next;

    assign run       = (state_reg == ST_RUN);
    assign bus.ready = run;

    // State and sweep-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: sweep one register per cycle, leave INIT after the last one
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == AW'(NREGS - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Single write port shared by the zero sweep and writeback; reg 0 writes are dropped
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (!reset) begin
            if (!run) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_reg;
                mem_wdata = '0;
            end else if (bus.wr_en && (bus.wr_addr != '0)) begin
                mem_we = 1'b1;
            end
        end
    end

    // Register storage, no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Per-register busy update: issue sets, writeback clears, issue wins on collision
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
        end else begin : g_reg
            logic iss_hit;
            logic wr_hit;
            assign iss_hit = bus.iss_en && (bus.iss_addr == AW'(gi));
            assign wr_hit  = bus.wr_en  && (bus.wr_addr  == AW'(gi));
            assign busy_next[gi] = !run    ? busy_reg[gi] :
                                   iss_hit ? 1'b1 :
                                   wr_hit  ? 1'b0 :
                                             busy_reg[gi];
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Independent combinational read ports with writeback forwarding
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] addr;
        logic          fwd;
        logic          quiet;
        assign addr  = bus.rd_addr[gi*AW +: AW];
        assign fwd   = bus.wr_en && (bus.wr_addr == addr);
        assign quiet = !run || (addr == '0);
        assign bus.rd_data[gi*XLEN +: XLEN] = quiet ? '0 :
                                              fwd   ? bus.wr_data :
                                                      mem[addr];
        // A forwarded value is no longer pending, so its busy flag is masked
        assign bus.rd_busy[gi] = (quiet || fwd) ? 1'b0 : busy_reg[addr];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomised checks for reg_file_mp with four read ports.
module tb_reg_file_mp;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    reg_file_mp_if #(.XLEN(64), .NREGS(32), .NRD(4)) bus ();

    reg_file_mp #(.XLEN(64), .NREGS(32), .NRD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        bus.rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.iss_en  = 1'b0;
        bus.iss_addr = '0;
    endtask

    function automatic logic [63:0] rd(input int k);
        return bus.rd_data[k*64 +: 64];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_sweep();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 64'hAA;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd5;
        set_rd(5'd5, 5'd5, 5'd0, 5'd31);
        do_reset();
        for (int i = 0; i < 32; i++) begin
            chk64($sformatf("sweep_ready_c%0d", i), 64'(bus.ready), 64'd0);
            total_cnt++;
            if (bus.rd_data !== '0 || bus.rd_busy !== 4'b0000)
                $display("FAIL sweep_rd_c%0d: got data 0x%0h busy %b expected 0 0",
                         i, bus.rd_data, bus.rd_busy);
            else pass_cnt++;
            tick();
        end
        chk64("sweep_ready_done", 64'(bus.ready), 64'd1);
        idle();
        #1;
        chk64("sweep_x5_zero", rd(0), 64'd0);
        chk64("sweep_x5_not_busy", 64'(bus.rd_busy), 64'd0);
        $display("test_reset_sweep done");
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        idle();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk64("midreset_not_ready", 64'(bus.ready), 64'd0);
        do_reset();
        wait_ready(n);
        chk64("midreset_latency", 64'(n), 64'd32);
        $display("test_mid_sweep_reset done: ready after %0d cycles", n);
    endtask

    task automatic test_forward();
        set_rd(5'd7, 5'd0, 5'd7, 5'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h1234;
        #1;
        chk64("fwd_same_cycle", rd(0), 64'h1234);
        chk64("fwd_port2", rd(2), 64'h1234);
        tick();
        bus.wr_en = 1'b0;
        #1;
        chk64("fwd_stored", rd(0), 64'h1234);
        set_rd(5'd0, 5'd0, 5'd7, 5'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 64'hFFFF;
        #1;
        chk64("x0_write_fwd", rd(0), 64'd0);
        chk64("x7_indep", rd(2), 64'h1234);
        tick();
        bus.wr_en = 1'b0;
        #1;
        chk64("x0_after_write", rd(1), 64'd0);
        $display("test_forward done");
    endtask

    task automatic test_issue_wb();
        set_rd(5'd3, 5'd3, 5'd3, 5'd4);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        #1;
        chk64("issue_same_cycle_busy", 64'(bus.rd_busy), 64'b0000);
        tick();
        bus.iss_en = 1'b0;
        #1;
        chk64("issue_next_busy", 64'(bus.rd_busy), 64'b0111);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'h55;
        #1;
        chk64("wb_busy_masked", 64'(bus.rd_busy), 64'b0000);
        chk64("wb_data_fwd", rd(1), 64'h55);
        tick();
        bus.wr_en = 1'b0;
        #1;
        chk64("wb_busy_cleared", 64'(bus.rd_busy), 64'b0000);
        chk64("wb_data_stored", rd(0), 64'h55);
        $display("test_issue_wb done");
    endtask

    task automatic test_back_to_back();
        set_rd(5'd9, 5'd9, 5'd9, 5'd9);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 64'h99;
        #1;
        chk64("coll_same_busy", 64'(bus.rd_busy), 64'b0000);
        tick();
        idle();
        #1;
        chk64("coll_issue_wins", 64'(bus.rd_busy), 64'b1111);
        chk64("coll_data", rd(3), 64'h99);
        set_rd(5'd0, 5'd0, 5'd0, 5'd9);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        tick();
        bus.iss_en = 1'b0;
        #1;
        chk64("issue_x0_ignored", 64'(bus.rd_busy), 64'b1000);
        chk64("issue_x0_data", rd(0), 64'd0);
        $display("test_back_to_back done");
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic test_random();
        logic [63:0]  mem_m [32];
        logic [31:0]  busy_m;
        logic [4:0]   addrs [4];
        logic [255:0] exp_d;
        logic [3:0]   exp_b;
        int           n;
        int           errs;
        idle();
        do_reset();
        wait_ready(n);
        chk64("rand_ready", 64'(n), 64'd32);
        for (int r = 0; r < 32; r++) mem_m[r] = '0;
        busy_m = '0;
        addrs[0] = 5'd1; addrs[1] = 5'd1; addrs[2] = 5'd0; addrs[3] = 5'd31;
        set_rd(addrs[0], addrs[1], addrs[2], addrs[3]);
        errs = 0;
        for (int c = 0; c < 10000; c++) begin
            bus.wr_en    = 1'($urandom_range(0, 1));
            bus.wr_addr  = pick_addr();
            bus.wr_data  = {$urandom, $urandom};
            bus.iss_en   = ($urandom_range(0, 3) == 0);
            bus.iss_addr = pick_addr();
            #1;
            for (int k = 0; k < 4; k++) begin
                if (addrs[k] == 5'd0) begin
                    exp_d[k*64 +: 64] = '0;
                    exp_b[k] = 1'b0;
                end else if (bus.wr_en && bus.wr_addr == addrs[k]) begin
                    exp_d[k*64 +: 64] = bus.wr_data;
                    exp_b[k] = 1'b0;
                end else begin
                    exp_d[k*64 +: 64] = mem_m[addrs[k]];
                    exp_b[k] = busy_m[addrs[k]];
                end
            end
            total_cnt++;
            if (bus.rd_data !== exp_d) begin
                $display("FAIL rand_data_c%0d: got 0x%0h expected 0x%0h", c, bus.rd_data, exp_d);
                errs++;
            end else pass_cnt++;
            total_cnt++;
            if (bus.rd_busy !== exp_b) begin
                $display("FAIL rand_busy_c%0d: got %b expected %b", c, bus.rd_busy, exp_b);
                errs++;
            end else pass_cnt++;
            tick();
            if (bus.wr_en && bus.wr_addr != 5'd0) begin
                mem_m[bus.wr_addr] = bus.wr_data;
                if (!(bus.iss_en && bus.iss_addr == bus.wr_addr)) busy_m[bus.wr_addr] = 1'b0;
            end
            if (bus.iss_en && bus.iss_addr != 5'd0) busy_m[bus.iss_addr] = 1'b1;
        end
        idle();
        $display("test_random done: 10000 cycles, %0d bad", errs);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1'b0;
        idle();
        set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        test_reset_sweep();
        test_mid_sweep_reset();
        test_forward();
        test_issue_wb();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
